regbank: RTL

General-purpose register bank for the A3 CPU: 64 registers × 64 bits, addressed by 6-bit selector. It is the receiving end of the control unit's register-write interface (`regbank_we` / `regbank_sel` / value). It serves two independent registered read ports to the datapath. After reset it runs a hardware clear sequence that zeroes every register before accepting traffic.

---
 rtl/regbank_pkg.sv | 17 +
 rtl/regbank_rdport.sv | 71 +++++++
 rtl/regbank.sv | 136 +++++++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// regbank_pkg: shared types and default sizes for the A3 register bank.
//   regbank_state_e    : clear-sequence FSM states
//   REGBANK_COUNT      : default number of registers
//   REGBANK_WIDTH      : default bits per register
//   REGBANK_SEL_WIDTH  : default selector width (log2 of REGBANK_COUNT)
package regbank_pkg;

  typedef enum logic {
    REGBANK_CLEAR = 1'b0,
    REGBANK_RUN   = 1'b1
  } regbank_state_e;

  localparam int REGBANK_COUNT     = 64;
  localparam int REGBANK_WIDTH     = 64;
  localparam int REGBANK_SEL_WIDTH = 6;

endpackage

// File: rtl/regbank_rdport.sv
// regbank_rdport: one registered read port of the register bank.
// Optional feature macro: REGBANK_BYPASS_EN (write-first forwarding when a
// same-cycle write targets the index being read; read-first when undefined).
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   run_en_i    in   bank is out of the clear sequence
//   req_i       in   read request
//   sel_i       in   read index
//   mem_rdata_i in   array contents at sel_i (pre-write value)
//   wr_en_i     in   write committing at this edge
//   wr_sel_i    in   write index
//   wr_data_i   in   write data
//   data_o      out  registered read data, holds when no request
//   valid_o     out  data_o was loaded by a request at the previous edge
module regbank_rdport #(
  parameter int REG_WIDTH = 64,
  parameter int SEL_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_en_i,
  input  logic                 req_i,
  input  logic [SEL_WIDTH-1:0] sel_i,
  input  logic [REG_WIDTH-1:0] mem_rdata_i,
  input  logic                 wr_en_i,
  input  logic [SEL_WIDTH-1:0] wr_sel_i,
  input  logic [REG_WIDTH-1:0] wr_data_i,
  output logic [REG_WIDTH-1:0] data_o,
  output logic                 valid_o
);

  logic [REG_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic [REG_WIDTH-1:0] rd_val;

`ifdef REGBANK_BYPASS_EN
  logic hit;
  // A write landing on the same index this edge wins over the stale array value.
  assign hit    = wr_en_i && (wr_sel_i == sel_i);
  assign rd_val = hit ? wr_data_i : mem_rdata_i;
`else
  // Read-first: the array still holds the pre-write value during this cycle.
  logic unused_wr;
  assign unused_wr = ^{wr_en_i, wr_sel_i, wr_data_i};
  assign rd_val    = mem_rdata_i;
`endif

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (run_en_i && req_i) begin
      data_d  = rd_val;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/regbank.sv
// regbank: 64 x 64-bit general-purpose register bank for the A3 CPU.
// One write port from the control unit, two independent registered read
// ports. After reset a hardware sequence zeroes every entry before ready.
// Optional feature macro: REGBANK_BYPASS_EN (same-cycle write/read of the
// same index returns the new data; otherwise the old data is returned).
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   regbank_we     in   write strobe
//   regbank_sel    in   write index
//   regbank_valin  in   write data
//   wr_ack         out  pulse: write at previous edge committed
//   rd_a_req/sel   in   port A request / index
//   rd_a_data      out  port A read data
//   rd_a_valid     out  port A data valid
//   rd_b_*              same as port A for port B
//   ready          out  clear sequence finished
module regbank
  import regbank_pkg::*;
#(
  parameter int REG_COUNT = REGBANK_COUNT,
  parameter int REG_WIDTH = REGBANK_WIDTH,
  parameter int SEL_WIDTH = REGBANK_SEL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 regbank_we,
  input  logic [SEL_WIDTH-1:0] regbank_sel,
  input  logic [REG_WIDTH-1:0] regbank_valin,
  output logic                 wr_ack,
  input  logic                 rd_a_req,
  input  logic [SEL_WIDTH-1:0] rd_a_sel,
  output logic [REG_WIDTH-1:0] rd_a_data,
  output logic                 rd_a_valid,
  input  logic                 rd_b_req,
  input  logic [SEL_WIDTH-1:0] rd_b_sel,
  output logic [REG_WIDTH-1:0] rd_b_data,
  output logic                 rd_b_valid,
  output logic                 ready
);

  // Extra index bit keeps the terminal value unambiguous.
  localparam logic [SEL_WIDTH:0] CLEAR_LAST = (SEL_WIDTH+1)'(REG_COUNT - 1);

  logic [REG_WIDTH-1:0] mem [REG_COUNT];

  regbank_state_e     state_q;
  logic [SEL_WIDTH:0] clear_idx_q;
  logic               wr_ack_q;
  logic               ready_q;

  logic run_en;
  logic clr_we;
  logic wr_en;

  assign run_en = (state_q == REGBANK_RUN);
  assign clr_we = !rst && (state_q == REGBANK_CLEAR);
  assign wr_en  = !rst && run_en && regbank_we;

  // Clear FSM, write acknowledge and ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= REGBANK_CLEAR;
      clear_idx_q <= '0;
      wr_ack_q    <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      case (state_q)
        REGBANK_CLEAR: begin
          wr_ack_q    <= 1'b0;
          clear_idx_q <= clear_idx_q + 1'b1;
          if (clear_idx_q == CLEAR_LAST) begin
            state_q <= REGBANK_RUN;
            ready_q <= 1'b1;
          end
        end
        REGBANK_RUN: begin
          wr_ack_q <= regbank_we;
        end
        default: begin
          state_q     <= REGBANK_CLEAR;
          clear_idx_q <= '0;
          wr_ack_q    <= 1'b0;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  // Storage: not reset; zeroed by the clear sequence instead.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clear_idx_q[SEL_WIDTH-1:0]] <= '0;
    end else if (wr_en) begin
      mem[regbank_sel] <= regbank_valin;
    end
  end

  regbank_rdport #(
    .REG_WIDTH (REG_WIDTH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rd_a (
    .clk         (clk),
    .rst         (rst),
    .run_en_i    (run_en),
    .req_i       (rd_a_req),
    .sel_i       (rd_a_sel),
    .mem_rdata_i (mem[rd_a_sel]),
    .wr_en_i     (wr_en),
    .wr_sel_i    (regbank_sel),
    .wr_data_i   (regbank_valin),
    .data_o      (rd_a_data),
    .valid_o     (rd_a_valid)
  );

  regbank_rdport #(
    .REG_WIDTH (REG_WIDTH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rd_b (
    .clk         (clk),
    .rst         (rst),
    .run_en_i    (run_en),
    .req_i       (rd_b_req),
    .sel_i       (rd_b_sel),
    .mem_rdata_i (mem[rd_b_sel]),
    .wr_en_i     (wr_en),
    .wr_sel_i    (regbank_sel),
    .wr_data_i   (regbank_valin),
    .data_o      (rd_b_data),
    .valid_o     (rd_b_valid)
  );

  assign wr_ack = wr_ack_q;
  assign ready  = ready_q;

endmodule
